// File: rtl/filter_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : filter_buffer_ctrl
// Description : Filter buffer for one PE engine. Stores a filter set from the
//               loader stream bank-interleaved over TOUT single-port RAM banks
//               and serves one word per bank, one cycle after each read request.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_buffer_ctrl #(
    parameter int FILTER_DW     = 72,
    parameter int FILTER_BUF_AW = 10,
    parameter int TOUT          = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_load_start,
    input  logic [FILTER_BUF_AW:0]   i_cfg_words,
    input  logic                     i_release,
    input  logic                     i_wr_vld,
    input  logic [FILTER_DW-1:0]     i_wr_data,
    input  logic                     i_wr_last,
    output logic                     o_wr_rdy,
    output logic                     o_load_done,
    output logic                     o_fb_req_possible,
    input  logic                     i_fb_req,
    input  logic [FILTER_BUF_AW-1:0] i_fb_addr,
    output logic [FILTER_DW-1:0]     o_fb_data0,
    output logic [FILTER_DW-1:0]     o_fb_data1,
    output logic [FILTER_DW-1:0]     o_fb_data2,
    output logic [FILTER_DW-1:0]     o_fb_data3,
    output logic [1:0]               o_err
);

    // Word counter must hold TOUT * 2^FILTER_BUF_AW (TOUT fixed at 4).
    localparam int         c_CNT_W = FILTER_BUF_AW + 3;
    localparam int         c_DEPTH = 2 ** FILTER_BUF_AW;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_READY = 2'd2;

    logic [1:0]               r_state;
    logic [FILTER_BUF_AW:0]   r_cfg_words;
    logic [c_CNT_W-1:0]       r_word_cnt;
    logic [1:0]               r_bank;
    logic [FILTER_BUF_AW-1:0] r_waddr;
    logic                     r_load_done;
    logic [1:0]               r_err;

    logic [c_CNT_W-1:0]       w_total;
    logic                     w_accept;
    logic                     w_last_word;
    logic                     w_rd_legal;
    logic                     w_rd_illegal;
    logic [FILTER_DW-1:0]     w_rdata [TOUT];

    // Total words in the set = TOUT * cfg_words.
    assign w_total      = {r_cfg_words, 2'b00};
    assign o_wr_rdy     = (r_state == c_LOAD);
    assign w_accept     = i_wr_vld && o_wr_rdy;
    // The word being offered now is the final one of the set.
    assign w_last_word  = ((r_word_cnt + c_CNT_W'(1)) == w_total);
    assign w_rd_legal   = i_fb_req && (r_state == c_READY)
                          && ({1'b0, i_fb_addr} < r_cfg_words);
    assign w_rd_illegal = i_fb_req && !w_rd_legal;

    assign o_load_done       = r_load_done;
    assign o_fb_req_possible = (r_state == c_READY);
    assign o_err             = r_err;
    assign o_fb_data0        = w_rdata[0];
    assign o_fb_data1        = w_rdata[1];
    assign o_fb_data2        = w_rdata[2];
    assign o_fb_data3        = w_rdata[3];

    // Load/ready sequencing and the bank-interleaved write pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_cfg_words <= '0;
            r_word_cnt  <= '0;
            r_bank      <= '0;
            r_waddr     <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (i_load_start) begin
                        r_state     <= c_LOAD;
                        r_cfg_words <= i_cfg_words;
                        r_word_cnt  <= '0;
                        r_bank      <= '0;
                        r_waddr     <= '0;
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        r_word_cnt <= r_word_cnt + c_CNT_W'(1);
                        r_bank     <= r_bank + 2'd1;
                        if (r_bank == 2'(TOUT - 1)) begin
                            r_waddr <= r_waddr + FILTER_BUF_AW'(1);
                        end
                    end
                    // An empty set completes without any writes.
                    if ((w_total == '0) || (w_accept && w_last_word)) begin
                        r_state     <= c_READY;
                        r_load_done <= 1'b1;
                    end
                end
                c_READY: begin
                    if (i_release) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Sticky error flags: mismatched last flag and reads outside a resident set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
        end else begin
            if (w_accept && (i_wr_last != w_last_word)) begin
                r_err[0] <= 1'b1;
            end
            if (w_rd_illegal) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    generate
        for (genvar b = 0; b < TOUT; b++) begin : g_bank
            logic [FILTER_DW-1:0] mem [c_DEPTH];
            logic [FILTER_DW-1:0] r_rdata;

            // RAM write port: contents are deliberately not reset.
            always_ff @(posedge clk) begin
                if (w_accept && (r_bank == 2'(b))) begin
                    mem[r_waddr] <= i_wr_data;
                end
            end

            // Registered read port: holds when idle, zeroes on an illegal read.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_rdata <= '0;
                end else if (w_rd_legal) begin
                    r_rdata <= mem[i_fb_addr];
                end else if (w_rd_illegal) begin
                    r_rdata <= '0;
                end
            end

            assign w_rdata[b] = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_filter_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_buffer_ctrl
// Description : Directed self-checking bench for filter_buffer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_buffer_ctrl;

    localparam int c_DW = 72;
    localparam int c_AW = 10;

    logic              clk;
    logic              rstn;
    logic              i_load_start;
    logic [c_AW:0]     i_cfg_words;
    logic              i_release;
    logic              i_wr_vld;
    logic [c_DW-1:0]   i_wr_data;
    logic              i_wr_last;
    logic              o_wr_rdy;
    logic              o_load_done;
    logic              o_fb_req_possible;
    logic              i_fb_req;
    logic [c_AW-1:0]   i_fb_addr;
    logic [c_DW-1:0]   o_fb_data0;
    logic [c_DW-1:0]   o_fb_data1;
    logic [c_DW-1:0]   o_fb_data2;
    logic [c_DW-1:0]   o_fb_data3;
    logic [1:0]        o_err;

    int n_vec = 0;
    int n_err = 0;

    filter_buffer_ctrl #(
        .FILTER_DW     (c_DW),
        .FILTER_BUF_AW (c_AW),
        .TOUT          (4)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_load_start      (i_load_start),
        .i_cfg_words       (i_cfg_words),
        .i_release         (i_release),
        .i_wr_vld          (i_wr_vld),
        .i_wr_data         (i_wr_data),
        .i_wr_last         (i_wr_last),
        .o_wr_rdy          (o_wr_rdy),
        .o_load_done       (o_load_done),
        .o_fb_req_possible (o_fb_req_possible),
        .i_fb_req          (i_fb_req),
        .i_fb_addr         (i_fb_addr),
        .o_fb_data0        (o_fb_data0),
        .o_fb_data1        (o_fb_data1),
        .o_fb_data2        (o_fb_data2),
        .o_fb_data3        (o_fb_data3),
        .o_err             (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [c_DW-1:0] e0, input logic [c_DW-1:0] e1,
                            input logic [c_DW-1:0] e2, input logic [c_DW-1:0] e3);
        chk({tag, "_b0"}, o_fb_data0, e0);
        chk({tag, "_b1"}, o_fb_data1, e1);
        chk({tag, "_b2"}, o_fb_data2, e2);
        chk({tag, "_b3"}, o_fb_data3, e3);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [c_DW-1:0] d, input logic last);
        i_wr_vld  = 1'b1;
        i_wr_data = d;
        i_wr_last = last;
        tick();
        i_wr_vld  = 1'b0;
        i_wr_last = 1'b0;
    endtask

    task automatic read(input logic [c_AW-1:0] a);
        i_fb_req  = 1'b1;
        i_fb_addr = a;
        tick();
        i_fb_req  = 1'b0;
    endtask

    task automatic start(input logic [c_AW:0] n);
        i_load_start = 1'b1;
        i_cfg_words  = n;
        tick();
        i_load_start = 1'b0;
    endtask

    initial begin
        int  j;
        int  cyc;
        logic rdy;

        rstn = 1'b0; i_load_start = 1'b0; i_cfg_words = '0; i_release = 1'b0;
        i_wr_vld = 1'b0; i_wr_data = '0; i_wr_last = 1'b0; i_fb_req = 1'b0; i_fb_addr = '0;
        tick(); tick();

        // Reset state
        chk("rst_wr_rdy", o_wr_rdy, 0);
        chk("rst_load_done", o_load_done, 0);
        chk("rst_req_possible", o_fb_req_possible, 0);
        chk_data("rst_data", 0, 0, 0, 0);
        chk("rst_err", o_err, 0);
        rstn = 1'b1;
        tick();

        // Clean load of 3 words per bank, values 1..12
        start(3);
        chk("load1_wr_rdy", o_wr_rdy, 1);
        for (int k = 1; k <= 11; k++) push(k, 1'b0);
        chk("load1_done_early", o_load_done, 0);
        chk("load1_possible_early", o_fb_req_possible, 0);
        push(12, 1'b1);
        chk("load1_done", o_load_done, 1);
        chk("load1_possible", o_fb_req_possible, 1);
        chk("load1_wr_rdy_off", o_wr_rdy, 0);
        tick();
        chk("load1_done_pulse", o_load_done, 0);
        chk("load1_err", o_err, 0);

        // Single read, then back-to-back reads, then hold
        read(2);
        chk_data("rd_a2", 72'h9, 72'hA, 72'hB, 72'hC);
        i_fb_req = 1'b1; i_fb_addr = 0; tick();
        chk_data("b2b_a0", 1, 2, 3, 4);
        i_fb_addr = 1; tick();
        chk_data("b2b_a1", 5, 6, 7, 8);
        i_fb_addr = 2; tick();
        chk_data("b2b_a2", 72'h9, 72'hA, 72'hB, 72'hC);
        i_fb_req = 1'b0; tick();
        chk_data("hold", 72'h9, 72'hA, 72'hB, 72'hC);
        chk("b2b_err", o_err, 0);

        // Release together with a read and a (ignored) load start
        i_release = 1'b1; i_load_start = 1'b1; i_cfg_words = 5;
        read(1);
        i_release = 1'b0; i_load_start = 1'b0;
        chk_data("rel_rd_a1", 5, 6, 7, 8);
        chk("rel_possible", o_fb_req_possible, 0);
        chk("rel_start_ignored", o_wr_rdy, 0);

        // Read during LOAD, early last flag on word 5
        start(3);
        read(0);
        chk("ld_rd_data0", o_fb_data0, 0);
        chk("ld_rd_err", o_err, 2'b10);
        for (int k = 1; k <= 5; k++) push(72'h10 + k, k == 5);
        chk("early_last_err", o_err, 2'b11);
        chk("early_last_wr_rdy", o_wr_rdy, 1);
        for (int k = 6; k <= 12; k++) push(72'h10 + k, 1'b0);
        chk("early_last_done", o_load_done, 1);
        chk("early_last_possible", o_fb_req_possible, 1);
        read(2);
        chk_data("ld2_a2", 72'h19, 72'h1A, 72'h1B, 72'h1C);
        read(3);
        chk_data("oob_rd", 0, 0, 0, 0);
        chk("oob_err", o_err, 2'b11);

        // Asynchronous reset mid-LOAD
        i_release = 1'b1; tick(); i_release = 1'b0;
        start(2);
        push(72'h55, 1'b0); push(72'h56, 1'b0); push(72'h57, 1'b0);
        rstn = 1'b0;
        #1;
        chk("async_wr_rdy", o_wr_rdy, 0);
        chk("async_possible", o_fb_req_possible, 0);
        chk("async_err", o_err, 0);
        chk("async_done", o_load_done, 0);
        tick();
        rstn = 1'b1;
        tick();

        // New load of 16 words per bank with randomly gapped valid
        start(16);
        j = 0;
        cyc = 0;
        while (j < 64 && cyc < 2000) begin
            i_wr_vld  = 1'($urandom_range(0, 1));
            i_wr_data = 72'h100 + j;
            i_wr_last = (j == 63);
            rdy = o_wr_rdy;
            tick();
            if (i_wr_vld && rdy) j++;
            cyc++;
        end
        i_wr_vld = 1'b0; i_wr_last = 1'b0;
        chk("rand_count", j, 64);
        chk("rand_wr_rdy_off", o_wr_rdy, 0);
        chk("rand_possible", o_fb_req_possible, 1);
        chk("rand_done", o_load_done, 1);
        chk("rand_err", o_err, 0);
        read(15);
        chk_data("rand_a15", 72'h13C, 72'h13D, 72'h13E, 72'h13F);
        read(0);
        chk_data("rand_a0", 72'h100, 72'h101, 72'h102, 72'h103);

        // Empty set: IDLE -> LOAD -> READY with no writes
        i_release = 1'b1; tick(); i_release = 1'b0;
        start(0);
        chk("zero_load_rdy", o_wr_rdy, 1);
        chk("zero_load_possible", o_fb_req_possible, 0);
        tick();
        chk("zero_ready_possible", o_fb_req_possible, 1);
        chk("zero_ready_wr_rdy", o_wr_rdy, 0);
        read(0);
        chk("zero_rd_data0", o_fb_data0, 0);
        chk("zero_rd_err", o_err, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_buffer_ctrl.md
Name: filter_buffer_ctrl

Overview:
- Responder side of the filter-buffer read interface driven by the PE engine: `fb_req_possible`, `o_fb_req`/`o_fb_addr` and `fb_data0..3_in`.
- Accepts filter words from the DMA/loader stream and stores them bank-interleaved across Tout single-port RAM banks.
- Asserts `o_fb_req_possible` once a full filter set is resident, then returns one word per bank one cycle after each read request.
- Sits between the AXI/DMA filter loader and pe_engine; one instance per PE engine.

Parameters:
- FILTER_DW, 72, width of one filter word (K*K weights of 8 bit).
- FILTER_BUF_AW, 10, per-bank word address width; bank depth = 2^FILTER_BUF_AW.
- Tout, 4, number of banks (output channels served per read); fixed to 4 in this revision.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- i_load_start  in  1  one-cycle pulse: begin loading a filter set (honoured only in IDLE)
- i_cfg_words  in  FILTER_BUF_AW+1  words per bank in the set (= q_channel*Tin); latched on i_load_start
- i_release  in  1  one-cycle pulse: layer finished, free buffer (honoured only in READY)
- i_wr_vld  in  1  loader word valid
- i_wr_data  in  FILTER_DW  loader word
- i_wr_last  in  1  final word of set flag
- o_wr_rdy  out  1  buffer accepts a word
- o_load_done  out  1  one-cycle pulse when the set is complete
- o_fb_req_possible  out  1  set resident, reads permitted
- i_fb_req  in  1  read request from PE engine
- i_fb_addr  in  FILTER_BUF_AW  per-bank read address
- o_fb_data0 .. o_fb_data3  out  FILTER_DW each  bank 0..3 read data
- o_err  out  2  sticky errors: [0] length mismatch, [1] illegal read

Behaviour:
- Reset values: o_wr_rdy=0, o_load_done=0, o_fb_req_possible=0, o_fb_data*=0, o_err=0, state=IDLE, counters=0. RAM contents are not reset.
- State machine:
  - IDLE -> LOAD on i_load_start. Latch i_cfg_words; clear word counter and bank counter.
  - LOAD -> READY when the accepted word count reaches Tout*cfg_words.
  - READY -> IDLE on i_release.
  - i_load_start outside IDLE and i_release outside READY are ignored.
  - A cfg_words value of 0 goes IDLE -> LOAD -> READY in 2 cycles with no writes.
- Write path:
  - o_wr_rdy = (state==LOAD); a transfer occurs when i_wr_vld && o_wr_rdy.
  - Word j of the set goes to bank j mod 4, address j div 4. The bank counter wraps 3 -> 0; the address increments on that wrap.
  - The cycle after the final word is accepted: state=READY, o_fb_req_possible=1, o_load_done pulses high for 1 cycle.
- Length check (sets o_err[0], sticky until reset):
  - i_wr_last on a word other than the final one. Loading continues to the count regardless.
  - Final word arriving without i_wr_last.
- Read path:
  - A read is legal when i_fb_req=1, state==READY and i_fb_addr < cfg_words.
  - All 4 banks are read at i_fb_addr; registered data appears on o_fb_data0..3 exactly 1 cycle after the request cycle (FB_DELAY=1).
  - Back-to-back requests every cycle are supported at full throughput.
  - Without a request, o_fb_data* hold their last value.
  - Illegal read (state≠READY or address out of range): o_fb_data* are driven to 0 the next cycle and o_err[1] is set (sticky).
- Simultaneous events:
  - i_release and i_fb_req in the same READY cycle: the read is served (data next cycle), then the state goes IDLE.
  - i_load_start in the same cycle as i_release: start is ignored because the state is not IDLE.
- Asynchronous reset mid-LOAD or mid-READY returns to IDLE immediately; partial data is discarded logically and a new i_load_start is required.

Test Plan:
- Load cfg_words=3 with words 0x01..0x0C, i_wr_last on the 12th -> o_load_done pulses 1 cycle after the 12th accept; a read at addr 2 returns bank0..3 = 0x09,0x0A,0x0B,0x0C one cycle later; o_err=0.
- Back-to-back reads at addr 0,1,2 in consecutive cycles -> data {1,2,3,4}, {5,6,7,8}, {9..C} on the three following cycles.
- i_wr_vld toggled randomly during LOAD with cfg_words=16 -> exactly 64 words stored; o_wr_rdy drops the cycle after the 64th accept; o_fb_req_possible=1.
- i_wr_last on word 5 of 12 -> o_err[0]=1; load still completes at word 12.
- Read during LOAD, and read at addr=cfg_words in READY -> data 0 the next cycle, o_err[1]=1.
- i_release together with a read at addr 1 -> addr-1 data returned; o_fb_req_possible=0 the next cycle. Assert rstn mid-LOAD -> all outputs 0, state IDLE, new load accepted.
